// File: rtl/l2_bus_pkg.sv
// Shared L2 external-bus encodings: op codes, snoop results, responder FSM
// states and the address helpers the L2 controller also uses.
package l2_bus_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_INVAL = 2'd2,
      OP_RFO   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      SN_HIT   = 2'd0,
      SN_HITM  = 2'd1,
      SN_NOHIT = 2'd2
   } snoop_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNOOP,
      ST_WAIT,
      ST_FILL,
      ST_SINK
   } state_e;

   function automatic snoop_e snoop_decode(input logic [1:0] lo);
      snoop_e r;
      case (lo)
         2'b00:   r = SN_HIT;
         2'b01:   r = SN_HITM;
         default: r = SN_NOHIT;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] line_mask(input int unsigned off_w);
      return ~((64'd1 << off_w) - 64'd1);
   endfunction

endpackage

// File: rtl/l2_bus_beat_ctr.sv
// Loadable down-counter with zero flag; used for memory latency and
// for counting the beats remaining in a burst.
module l2_bus_beat_ctr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/l2_bus_responder.sv
// System side of the L2 external bus: snoop reply, line fills after a
// modelled memory latency, and writeback sinking with statistics.
module l2_bus_responder
   import l2_bus_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int BEAT_W  = 64,
   parameter int BEATS   = 8,
   parameter int MEM_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              snoop_valid,
   output logic [1:0]        snoop_result,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [BEAT_W-1:0] rdata,
   output logic              rdata_last,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [BEAT_W-1:0] wdata,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wb_count,
   output logic              err
);

   localparam int OFF_W = $clog2(BEATS * BEAT_W / 8);
   localparam int LW    = $clog2(2 * MEM_LAT + 1);
   localparam int BW    = $clog2(BEATS + 1);

   localparam logic [63:0]   MASK64 = line_mask(OFF_W);
   localparam logic [LW-1:0] LAT_N  = LW'(MEM_LAT - 1);
   localparam logic [LW-1:0] LAT_M  = LW'(2 * MEM_LAT - 1);
   localparam logic [BW-1:0] LAST_B = BW'(BEATS - 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   snoop_e            snoop_q, snoop_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
   logic              err_q, err_d;

   logic              accept, op_x;
   op_e               op_in;
   snoop_e            snoop_in;
   logic              rd_hs, wr_hs;
   logic              lat_dec, lat_zero;
   logic [LW-1:0]     lat_cnt;
   logic              beat_zero;
   logic [BW-1:0]     beat_rem, beat_idx;
   logic [31:0]       base32;
   logic              unused_w;

   assign unused_w = ^{wdata, lat_cnt};

   assign accept   = req_valid && (state_q == ST_IDLE);
   assign op_x     = $isunknown(req_op);
   assign op_in    = op_x ? OP_READ : op_e'(req_op);
   assign snoop_in = snoop_decode(req_addr[1:0]);
   assign rd_hs    = rdata_valid && rdata_ready;
   assign wr_hs    = wdata_valid && (state_q == ST_SINK);
   assign lat_dec  = (state_q == ST_SNOOP) || (state_q == ST_WAIT);
   assign beat_idx = LAST_B - beat_rem;
   assign base32   = 32'(base_q);

   // Latency starts at accept so the SNOOP cycle counts toward MEM_LAT.
   l2_bus_beat_ctr #(.W(LW)) u_lat (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .val_i  ((snoop_in == SN_HITM) ? LAT_M : LAT_N),
      .dec_i  (lat_dec),
      .cnt_o  (lat_cnt),
      .zero_o (lat_zero)
   );

   l2_bus_beat_ctr #(.W(BW)) u_beat (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .val_i  (LAST_B),
      .dec_i  (rd_hs || wr_hs),
      .cnt_o  (beat_rem),
      .zero_o (beat_zero)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      snoop_d  = snoop_q;
      base_d   = base_q;
      rd_cnt_d = rd_cnt_q;
      wb_cnt_d = wb_cnt_q;
      err_d    = err_q;
      if (wdata_valid && (state_q != ST_SINK))
         err_d = 1'b1;
      unique case (state_q)
         ST_IDLE: if (accept) begin
            op_d    = op_in;
            snoop_d = snoop_in;
            base_d  = req_addr & MASK64[ADDR_W-1:0];
            state_d = ST_SNOOP;
            if (op_x)
               err_d = 1'b1;
         end
         ST_SNOOP: begin
            unique case (op_q)
               OP_READ, OP_RFO: state_d = lat_zero ? ST_FILL : ST_WAIT;
               OP_WRITE:        state_d = ST_SINK;
               default:         state_d = ST_IDLE;
            endcase
         end
         ST_WAIT: if (lat_zero) state_d = ST_FILL;
         ST_FILL: if (rd_hs && beat_zero) begin
            state_d = ST_IDLE;
            if (rd_cnt_q != '1)
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
         end
         ST_SINK: if (wr_hs && beat_zero) begin
            state_d = ST_IDLE;
            if (wb_cnt_q != '1)
               wb_cnt_d = wb_cnt_q + CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_READ;
         snoop_q  <= SN_HIT;
         base_q   <= '0;
         rd_cnt_q <= '0;
         wb_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         snoop_q  <= snoop_d;
         base_q   <= base_d;
         rd_cnt_q <= rd_cnt_d;
         wb_cnt_q <= wb_cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      rdata        = '0;
      rdata_valid  = 1'b0;
      rdata_last   = 1'b0;
      snoop_valid  = 1'b0;
      snoop_result = 2'd0;
      if (state_q == ST_SNOOP) begin
         snoop_valid  = 1'b1;
         snoop_result = snoop_q;
      end
      if (state_q == ST_FILL) begin
         rdata_valid = 1'b1;
         rdata_last  = beat_zero;
         rdata[31:0] = base32 + 32'({beat_idx, 3'b000});
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign wdata_ready = (state_q == ST_SINK);
   assign rd_count    = rd_cnt_q;
   assign wb_count    = wb_cnt_q;
   assign err         = err_q;

endmodule

// File: tb/tb_l2_bus_responder.sv
// Directed bench for l2_bus_responder at default parameters.
module tb_l2_bus_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [31:0] req_addr = '0;
   logic        snoop_valid;
   logic [1:0]  snoop_result;
   logic        rdata_valid;
   logic        rdata_ready = 1'b1;
   logic [63:0] rdata;
   logic        rdata_last;
   logic        wdata_valid = 1'b0;
   logic        wdata_ready;
   logic [63:0] wdata = '0;
   logic [15:0] rd_count;
   logic [15:0] wb_count;
   logic        err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   l2_bus_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .snoop_valid  (snoop_valid),
      .snoop_result (snoop_result),
      .rdata_valid  (rdata_valid),
      .rdata_ready  (rdata_ready),
      .rdata        (rdata),
      .rdata_last   (rdata_last),
      .wdata_valid  (wdata_valid),
      .wdata_ready  (wdata_ready),
      .wdata        (wdata),
      .rd_count     (rd_count),
      .wb_count     (wb_count),
      .err          (err)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] addr);
      @(negedge clk);
      chk("idle_ready", req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // stall: 0 = always ready, 1 = ready pattern 1,0,0,1 repeating.
   // abort_b >= 0 pulls reset while that beat is presented.
   task automatic run_fill(input logic [1:0] op, input logic [31:0] addr,
                           input logic [1:0] exp_sn, input int exp_first,
                           input int stall, input int abort_b);
      int cyc, b, i;
      logic [31:0] base;
      base = addr & 32'hFFFF_FFC0;
      issue(op, addr);
      @(negedge clk);
      chk("snoop_v", snoop_valid, 1);
      chk("snoop_r", snoop_result, exp_sn);
      cyc = 1;
      @(negedge clk);
      cyc = 2;
      chk("snoop_once", snoop_valid, 0);
      while (!rdata_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("first_beat_cyc", cyc, exp_first);
      b = 0;
      i = 0;
      while (b < 8 && i < 200) begin
         if (stall != 0)
            rdata_ready = (i % 4 == 0) || (i % 4 == 3);
         else
            rdata_ready = 1'b1;
         chk("fill_valid", rdata_valid, 1);
         chk("fill_data", rdata, {32'h0, base + 32'(8 * b)});
         chk("fill_last", rdata_last, (b == 7));
         if (b == abort_b) begin
            rst_n = 1'b0;
            #1;
            chk("rst_rvalid", rdata_valid, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_rlast", rdata_last, 0);
            chk("rst_ready", req_ready, 1);
            chk("rst_rdcnt", rd_count, 0);
            chk("rst_err", err, 0);
            rdata_ready = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (rdata_ready)
            b++;
         i++;
         @(negedge clk);
      end
      rdata_ready = 1'b1;
      chk("fill_handshakes", b, 8);
      chk("fill_done", rdata_valid, 0);
      chk("fill_idle", req_ready, 1);
   endtask

   initial begin
      #1;
      chk("reset_ready", req_ready, 1);
      chk("reset_rvalid", rdata_valid, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_snoop", snoop_valid, 0);
      chk("reset_wready", wdata_ready, 0);
      chk("reset_cnts", {rd_count, wb_count}, 0);
      chk("reset_err", err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // READ, low bits 00 -> HIT, first beat at 1+MEM_LAT
      run_fill(2'd0, 32'h0000_1040, 2'd0, 5, 0, -1);
      chk("rd_cnt_1", rd_count, 1);

      // RFO, low bits 01 -> HITM, first beat at 1+2*MEM_LAT
      run_fill(2'd3, 32'h0000_2001, 2'd1, 9, 0, -1);
      chk("rd_cnt_2", rd_count, 2);

      // WRITE with gapped beats
      begin
         int n, g;
         issue(2'd1, 32'h0000_3000);
         @(negedge clk);
         chk("wr_snoop_v", snoop_valid, 1);
         chk("wr_snoop_r", snoop_result, 0);
         chk("wr_ready_snoop", wdata_ready, 0);
         chk("wr_req_busy", req_ready, 0);
         n = 0;
         g = 0;
         while (n < 8 && g < 100) begin
            @(negedge clk);
            chk("wr_ready_sink", wdata_ready, 1);
            wdata_valid = (g % 2 == 0);
            wdata = {32'hDEAD_0000, 32'(g)};
            if (wdata_valid)
               n++;
            @(posedge clk);
            #1 wdata_valid = 1'b0;
            g++;
         end
         @(negedge clk);
         chk("wr_idle", req_ready, 1);
         chk("wr_ready_off", wdata_ready, 0);
         chk("wb_cnt", wb_count, 1);
         chk("wr_err", err, 0);
      end

      // INVALIDATE -> single HIT pulse, idle at cycle 2
      issue(2'd2, 32'h0000_4000);
      @(negedge clk);
      chk("inv_snoop_v", snoop_valid, 1);
      chk("inv_snoop_r", snoop_result, 0);
      @(negedge clk);
      chk("inv_snoop_off", snoop_valid, 0);
      chk("inv_idle", req_ready, 1);
      chk("inv_nodata", rdata_valid, 0);
      chk("inv_cnts", {rd_count, wb_count}, {16'd2, 16'd1});

      // stalled fill, NOHIT
      run_fill(2'd0, 32'h0000_5006, 2'd2, 5, 1, -1);
      chk("rd_cnt_3", rd_count, 3);

      // stray writeback beat in IDLE -> sticky err
      @(negedge clk);
      wdata_valid = 1'b1;
      @(posedge clk);
      #1 wdata_valid = 1'b0;
      @(negedge clk);
      chk("err_set", err, 1);
      repeat (3) @(negedge clk);
      chk("err_sticky", err, 1);
      chk("err_wb_cnt", wb_count, 1);

      // reset during beat 3, then a clean READ
      run_fill(2'd0, 32'h0000_6000, 2'd0, 5, 0, 3);
      chk("post_rst_err", err, 0);
      run_fill(2'd0, 32'h0000_1040, 2'd0, 5, 0, -1);
      chk("post_rst_rdcnt", rd_count, 1);
      chk("post_rst_wbcnt", wb_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
